// File: rtl/uart_pkg.sv
// Shared UART definitions: baud count table, frame geometry, FSM states,
// and the parity / frame-building helpers used by the transmit side.
package uart_pkg;

    localparam int         FRAME_BITS = 11;
    localparam logic [3:0] FRAME_LAST = 4'd10;

    // Clocks per bit at 100 MHz; selects 12..15 fall back to 9600 baud.
    localparam logic [18:0] BAUD_COUNT [16] = '{
        19'd333333, 19'd83333, 19'd41667, 19'd20833,
        19'd10417,  19'd5208,  19'd2604,  19'd1736,
        19'd868,    19'd434,   19'd217,   19'd109,
        19'd10417,  19'd10417, 19'd10417, 19'd10417
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } tx_state_e;

    // Parity over 7 or 8 data bits; odd sense inverts the even result.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic       use_d7,
                                        input logic       odd);
        logic [7:0] masked;
        masked = use_d7 ? data : {1'b0, data[6:0]};
        return (^masked) ^ odd;
    endfunction

    // Eleven-bit line image, bit 0 goes out first: {stop, b10, b9, d6..d0, start}.
    function automatic logic [10:0] build_frame(input logic [7:0] data,
                                                input logic       eight,
                                                input logic       pen,
                                                input logic       ohel);
        logic b9;
        logic b10;
        case ({eight, pen})
            2'b00: begin
                b9  = 1'b1;
                b10 = 1'b1;
            end
            2'b01: begin
                b9  = parity_bit(data, 1'b0, ohel);
                b10 = 1'b1;
            end
            2'b10: begin
                b9  = data[7];
                b10 = 1'b1;
            end
            2'b11: begin
                b9  = data[7];
                b10 = parity_bit(data, 1'b1, ohel);
            end
            default: begin
                b9  = 1'b1;
                b10 = 1'b1;
            end
        endcase
        return {1'b1, b10, b9, data[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-time and bit-count timing for the transmitter. Both counters sit at
// zero while disabled, so every frame starts from a clean count.
module tx_bit_timer
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [18:0] bit_time_i,
    output logic        btu_o,
    output logic        done_o
);

    logic [18:0] count_q;
    logic [18:0] count_d;
    logic [3:0]  bit_q;
    logic [3:0]  bit_d;

    // Bit-time pulse on the last clock of a bit; frame done on the last bit.
    always_comb begin
        btu_o  = en_i && (count_q == (bit_time_i - 19'd1));
        done_o = btu_o && (bit_q == FRAME_LAST);
        if (!en_i) begin
            count_d = 19'd0;
            bit_d   = 4'd0;
        end else if (btu_o) begin
            count_d = 19'd0;
            bit_d   = done_o ? 4'd0 : (bit_q + 4'd1);
        end else begin
            count_d = count_q + 19'd1;
            bit_d   = bit_q;
        end
    end

    // Counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 19'd0;
            bit_q   <= 4'd0;
        end else begin
            count_q <= count_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: rtl/transmit_engine.sv
// UART transmitter: takes a byte from the processor output-port bus and
// sends start, 7/8 data bits LSB first, optional parity and stop bits.
module transmit_engine
    import uart_pkg::*;
#(
    parameter logic [15:0] DATA_PORT_ID  = 16'h0000,
    parameter int          WR_STROBE_BIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  baud,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic [15:0] writes,
    input  logic [15:0] port_id,
    input  logic [7:0]  out_port,
    output logic        tx,
    output logic        tx_rdy,
    output logic        tx_done
);

    tx_state_e   state_q;
    logic [7:0]  data_q;
    logic        eight_q;
    logic        pen_q;
    logic        ohel_q;
    logic [3:0]  baud_q;
    logic [10:0] shreg_q;
    logic        tx_rdy_q;
    logic        tx_done_q;

    logic        load_s;
    logic        timer_en_s;
    logic [18:0] bit_time_s;
    logic        btu_s;
    logic        frame_done_s;
    logic        unused_writes_s;

    // Accept a byte only when addressed, strobed and idle; pick the latched bit time.
    always_comb begin
        load_s          = writes[WR_STROBE_BIT] && (port_id == DATA_PORT_ID) && tx_rdy_q;
        timer_en_s      = (state_q == SHIFT);
        bit_time_s      = BAUD_COUNT[baud_q];
        unused_writes_s = ^writes;
    end

    tx_bit_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .en_i       (timer_en_s),
        .bit_time_i (bit_time_s),
        .btu_o      (btu_s),
        .done_o     (frame_done_s)
    );

    // Transmit FSM; the shift register's bit 0 drives the line directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= 8'h00;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            baud_q    <= 4'd0;
            shreg_q   <= 11'h7FF;
            tx_rdy_q  <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_s) begin
                        data_q   <= out_port;
                        eight_q  <= eight;
                        pen_q    <= pen;
                        ohel_q   <= ohel;
                        baud_q   <= baud;
                        tx_rdy_q <= 1'b0;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    shreg_q <= build_frame(data_q, eight_q, pen_q, ohel_q);
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (btu_s) begin
                        shreg_q <= {1'b1, shreg_q[10:1]};
                    end
                    if (frame_done_s) begin
                        state_q   <= IDLE;
                        tx_rdy_q  <= 1'b1;
                        tx_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    shreg_q  <= 11'h7FF;
                    tx_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx      = shreg_q[0];
    assign tx_rdy  = tx_rdy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_transmit_engine.sv
// Randomized self-checking bench for transmit_engine against a list-based
// frame model and per-cycle timing expectations.
module tb_transmit_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  baud;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [15:0] writes;
    logic [15:0] port_id;
    logic [7:0]  out_port;
    logic        tx;
    logic        tx_rdy;
    logic        tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    transmit_engine #(
        .DATA_PORT_ID  (16'h0000),
        .WR_STROBE_BIT (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .baud     (baud),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .writes   (writes),
        .port_id  (port_id),
        .out_port (out_port),
        .tx       (tx),
        .tx_rdy   (tx_rdy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clocks per bit for a baud select.
    function automatic int bench_k(input int b);
        int tbl[12] = '{333333, 83333, 41667, 20833, 10417, 5208,
                        2604, 1736, 868, 434, 217, 109};
        return (b >= 12) ? 10417 : tbl[b];
    endfunction

    // Line bits in send order: start, data, optional parity, then idle-high fill.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                                input logic p, input logic o);
        int bits[$];
        int dv   = int'(d);
        int ones = 0;
        int n    = e ? 8 : 7;
        logic [10:0] w;
        bits.push_back(0);
        for (int i = 0; i < n; i++) begin
            bits.push_back((dv >> i) & 1);
            ones += (dv >> i) & 1;
        end
        if (p) bits.push_back((ones % 2) ^ (o ? 1 : 0));
        while (bits.size() < 11) bits.push_back(1);
        for (int i = 0; i < 11; i++) w[i] = (bits[i] != 0);
        return w;
    endfunction

    // Drive a data-port write; returns one clock after the accepting edge.
    task automatic issue_write(input logic [7:0] d, input logic e, input logic p,
                               input logic o, input logic [3:0] b);
        out_port = d; eight = e; pen = p; ohel = o; baud = b;
        port_id  = 16'h0000;
        writes   = 16'h0001;
        @(posedge clk); #1;
        writes   = 16'h0000;
        // scramble config so any late sampling shows up
        eight    = 1'($urandom);
        pen      = 1'($urandom);
        ohel     = 1'($urandom);
        baud     = 4'($urandom_range(0, 11));
        out_port = 8'($urandom);
        check_eq("load_rdy_low", int'(tx_rdy), 0);
        check_eq("load_tx_idle", int'(tx), 1);
        check_eq("load_done_low", int'(tx_done), 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic e, input logic p,
                              input logic o, input logic [3:0] b, input bit poke);
        logic [10:0] exp_w;
        int k, rise, done_cnt, poke_at, tx_at_rise;
        int hits[11];
        exp_w = model_frame(d, e, p, o);
        k = bench_k(int'(b));
        rise = 0; done_cnt = 0; tx_at_rise = -1;
        foreach (hits[i]) hits[i] = 0;
        poke_at = $urandom_range(2, 11 * k - 2);
        issue_write(d, e, p, o, b);
        for (int c = 1; c <= 11 * k + 20 && rise == 0; c++) begin
            @(posedge clk); #1;
            if (tx_done) done_cnt++;
            if (tx_rdy) begin
                rise = c;
                tx_at_rise = int'(tx);
            end else if (((c - 1) / k) < 11 && tx == exp_w[(c - 1) / k]) begin
                hits[(c - 1) / k]++;
            end
            if (poke && c == poke_at) begin
                port_id = 16'h0000; out_port = 8'h3C; writes = 16'h0001;
            end else begin
                writes = 16'h0000;
            end
        end
        for (int s = 0; s < 11; s++) check_eq($sformatf("slot%0d_clocks", s), hits[s], k);
        check_eq("rdy_low_clocks", rise, 1 + 11 * k);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("tx_at_end", tx_at_rise, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int hi_tx, hi_rdy, lo_done, low_cnt;
        reset = 1'b1; writes = 16'h0000; port_id = 16'h0000; out_port = 8'h00;
        baud = 4'd11; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", int'(tx), 1);
        check_eq("rst_rdy", int'(tx_rdy), 1);
        check_eq("rst_done", int'(tx_done), 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Idle with no writes.
        hi_tx = 0; hi_rdy = 0; lo_done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (tx) hi_tx++;
            if (tx_rdy) hi_rdy++;
            if (!tx_done) lo_done++;
        end
        check_eq("idle_tx_high", hi_tx, 1000);
        check_eq("idle_rdy_high", hi_rdy, 1000);
        check_eq("idle_done_low", lo_done, 1000);

        // Misaddressed writes must not start a frame.
        port_id = 16'h0000; writes = 16'h0002; out_port = 8'h00;
        @(posedge clk); #1;
        port_id = 16'h0001; writes = 16'h0001;
        @(posedge clk); #1;
        writes = 16'h0000; port_id = 16'h0000;
        @(posedge clk); #1;
        check_eq("miswrite_rdy", int'(tx_rdy), 1);
        check_eq("miswrite_tx", int'(tx), 1);

        // Directed frames.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 4'd11, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 4'd11, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 4'd11, 1'b0);
        idle_cycles(5);
        // Mid-frame write ignored, then back-to-back write at the ready edge.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 4'd11, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0);
        idle_cycles(3);
        check_eq("after_b2b_rdy", int'(tx_rdy), 1);

        // Randomized frames, some back-to-back, some with mid-frame writes.
        for (int n = 0; n < 10; n++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 1) != 0) ? 4'd11 : 4'd10, 1'($urandom));
            if ($urandom_range(0, 1) != 0) idle_cycles($urandom_range(1, 20));
        end

        // Reset in the middle of slot 5 (d4 of A5 is 0).
        issue_write(8'hA5, 1'b1, 1'b0, 1'b0, 4'd11);
        idle_cycles(5 * 109 + 54);
        check_eq("pre_reset_tx", int'(tx), 0);
        reset = 1'b1;
        #1;
        check_eq("async_rst_tx", int'(tx), 1);
        check_eq("async_rst_rdy", int'(tx_rdy), 1);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0);

        // baud 13 uses the 9600 count: measure the start bit, then abandon.
        issue_write(8'h01, 1'b1, 1'b0, 1'b0, 4'd13);
        low_cnt = 0;
        for (int c = 0; c < 11000; c++) begin
            @(posedge clk); #1;
            if (!tx) low_cnt++;
            else if (low_cnt > 0) break;
        end
        check_eq("baud13_start_clocks", low_cnt, 10417);
        reset = 1'b1;
        #1;
        check_eq("abort_tx", int'(tx), 1);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_rdy", int'(tx_rdy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
